// File: rtl/bus_write_logger.sv
// Snoops bus writes into a timestamped record FIFO that is drained through a small CSR window.
// CSR ack and read data are registered one cycle after csr_req_i; a full FIFO drops new captures and sets OVF.
module bus_write_logger #(
    parameter logic [31:0] BASE  = 32'h0010_0000,
    parameter int          DEPTH = 8
) (
    input  logic        clk_i,
    input  logic        arst_n_i,
    input  logic        snp_req_i,
    input  logic        snp_we_i,
    input  logic [31:0] snp_addr_i,
    input  logic [31:0] snp_wdata_i,
    input  logic        csr_req_i,
    input  logic        csr_we_i,
    input  logic [7:0]  csr_addr_i,
    input  logic [31:0] csr_wdata_i,
    output logic        csr_ack_o,
    output logic [31:0] csr_rdata_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [7:0] OFF_CTRL   = 8'h2C;
    localparam logic [7:0] OFF_STATUS = 8'h50;
    localparam logic [7:0] OFF_W0     = 8'h54;
    localparam logic [7:0] OFF_W1     = 8'h58;
    localparam logic [7:0] OFF_W2     = 8'h5C;
    localparam logic [7:0] OFF_W3     = 8'h60;

    logic [31:0]   ts_q;
    logic [31:0]   seq_q;
    logic          en_q;
    logic          ovf_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [6:0]    count_q;

    logic [31:0] mem_ts   [DEPTH];
    logic [31:0] mem_addr [DEPTH];
    logic [31:0] mem_data [DEPTH];
    logic [31:0] mem_seq  [DEPTH];

    logic        csr_rd;
    logic        ctrl_wr;
    logic        clr;
    logic        empty;
    logic        full;
    logic        pop;
    logic        capture;
    logic        push;
    logic        drop;
    logic [31:0] rdata_d;
    logic        unused_wdata;

    assign csr_rd  = csr_req_i && !csr_we_i;
    assign ctrl_wr = csr_req_i && csr_we_i && (csr_addr_i == OFF_CTRL);
    assign clr     = ctrl_wr && csr_wdata_i[1];
    assign empty   = (count_q == 7'd0);
    assign full    = (count_q == 7'(DEPTH));
    assign pop     = csr_rd && (csr_addr_i == OFF_W3) && !empty;
    // A snooped write aimed at our own CTRL register is configuration traffic, not loggable data.
    assign capture = snp_req_i && snp_we_i && en_q && (snp_addr_i != BASE + 32'h2C);
    assign push    = capture && !clr && (!full || pop);
    assign drop    = capture && !clr && full && !pop;

    assign unused_wdata = ^csr_wdata_i[31:2];

    always_comb begin
        rdata_d = 32'd0;
        case (csr_addr_i)
            OFF_CTRL:   rdata_d = {31'd0, en_q};
            OFF_STATUS: rdata_d = {ovf_q, empty, 23'd0, count_q};
            OFF_W0:     rdata_d = empty ? 32'd0 : mem_ts[rd_ptr_q];
            OFF_W1:     rdata_d = empty ? 32'd0 : mem_addr[rd_ptr_q];
            OFF_W2:     rdata_d = empty ? 32'd0 : mem_data[rd_ptr_q];
            OFF_W3:     rdata_d = empty ? 32'd0 : mem_seq[rd_ptr_q];
            default:    rdata_d = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_ts[wr_ptr_q]   <= ts_q;
            mem_addr[wr_ptr_q] <= snp_addr_i;
            mem_data[wr_ptr_q] <= snp_wdata_i;
            mem_seq[wr_ptr_q]  <= seq_q;
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            ts_q        <= 32'd0;
            seq_q       <= 32'd0;
            en_q        <= 1'b0;
            ovf_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= 7'd0;
            csr_ack_o   <= 1'b0;
            csr_rdata_o <= 32'd0;
        end else begin
            ts_q        <= ts_q + 32'd1;
            csr_ack_o   <= csr_req_i;
            csr_rdata_o <= csr_rd ? rdata_d : 32'd0;
            if (ctrl_wr) begin
                en_q <= csr_wdata_i[0];
            end
            if (clr) begin
                seq_q    <= 32'd0;
                ovf_q    <= 1'b0;
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= 7'd0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + AW'(1);
                    seq_q    <= seq_q + 32'd1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + AW'(1);
                end
                if (drop) begin
                    ovf_q <= 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 7'd1;
                    2'b01:   count_q <= count_q - 7'd1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end
endmodule

// File: doc/bus_write_logger.md
BUS_WRITE_LOGGER -- requirements
Module: bus_write_logger

Interface
REQ-001 SHALL have parameter BASE, default 32'h00100000, meaning the logger CSR window base; the CTRL address is BASE+0x2C.
REQ-002 SHALL have parameter DEPTH, default 8, meaning record FIFO depth; power of 2, range 2..64.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port arst_n_i, input, 1, reset; asynchronous and active-low.
REQ-005 SHALL have port snp_req_i, input, 1, snooped bus request strobe, one cycle per transaction.
REQ-006 SHALL have port snp_we_i, input, 1, snooped write enable.
REQ-007 SHALL have port snp_addr_i, input, 32, snooped address.
REQ-008 SHALL have port snp_wdata_i, input, 32, snooped write data.
REQ-009 SHALL have port csr_req_i, input, 1, CSR access strobe.
REQ-010 SHALL have port csr_we_i, input, 1, CSR write enable.
REQ-011 SHALL have port csr_addr_i, input, 8, CSR byte offset from BASE.
REQ-012 SHALL have port csr_wdata_i, input, 32, CSR write data.
REQ-013 SHALL have port csr_ack_o, output, 1, CSR response strobe.
REQ-014 SHALL have port csr_rdata_o, output, 32, CSR read data, valid with csr_ack_o.

Function
REQ-015 SHALL implement a free-running 32-bit timestamp counter: +1 per cycle, wraps 0xFFFFFFFF->0.
REQ-016 SHALL implement CTRL at 0x2C: bit0 EN (R/W); bit1 CLR (write-1, self-clearing, reads 0).
REQ-017 SHALL capture a record in the cycle when snp_req_i=1, snp_we_i=1, EN=1 and snp_addr_i!=BASE+0x2C.
REQ-018 SHALL hold each record as four words: W0=timestamp at capture, W1=snp_addr_i, W2=snp_wdata_i, W3=sequence number.
REQ-019 SHALL keep a 32-bit sequence counter that increments once per accepted record, wraps, and is not advanced by dropped records.
REQ-020 SHALL make EN changes take effect for snoops from the cycle after the CTRL write.
REQ-021 SHALL expose STATUS at 0x50: bit31 OVF (sticky), bit30 EMPTY, bits[6:0] record count (0..DEPTH); all other bits 0.
REQ-022 SHALL present the head record at 0x54 (W0), 0x58 (W1), 0x5C (W2), 0x60 (W3).
REQ-023 SHALL pop the head record on a CSR read of 0x60 when the FIFO is non-empty; reads of 0x54..0x5C do not pop.
REQ-024 SHALL return 0 on reads of 0x54..0x60 while the FIFO is empty, with no pop and no pointer change.
REQ-025 SHALL assert csr_ack_o exactly one cycle after every csr_req_i, for reads and writes, with registered csr_rdata_o.
REQ-026 SHALL return 0 on reads of unmapped offsets and ignore writes to them; writes to 0x50..0x60 are ignored.
REQ-027 SHALL, when full, drop a new capture, set OVF, and leave the FIFO unchanged.
REQ-028 SHALL, when full with a capture and a 0x60 pop in the same cycle, accept both: count stays DEPTH and OVF is unchanged.
REQ-029 SHALL, when empty with a capture and a 0x60 read in the same cycle, return 0 and store the record: count becomes 1.
REQ-030 SHALL make CLR empty the FIFO, clear OVF and zero the sequence counter, with any same-cycle capture discarded; EN keeps the written bit0 value.
REQ-031 SHALL wrap the FIFO read and write pointers modulo DEPTH.
REQ-032 SHALL accept only CSR accesses where csr_req_i is high.

Reset
REQ-033 SHALL, on arst_n_i=0 and regardless of clock, set csr_ack_o=0, csr_rdata_o=0, EN=0, OVF=0, count=0, pointers=0, sequence=0 and timestamp=0.
REQ-034 SHALL treat reset during capture or pop as aborting it; the FIFO is empty after release.

Verification
REQ-035 SHALL pass: after reset, read 0x50 -> 0x40000000; read 0x60 -> 0.
REQ-036 SHALL pass: EN=1, then snoop writes (0x00100004,0x00111111) and (0x00100010,0x00222222) -> STATUS count 2; reads of 0x58/0x5C/0x60 -> 0x00100004/0x00111111/0; the second record's W3 = 1.
REQ-037 SHALL pass: with DEPTH=8 and 9 captures -> STATUS 0x80000008; the first popped W2 is the first write's data.
REQ-038 SHALL pass: with FIFO full, a same-cycle capture and 0x60 pop -> count 8, OVF unchanged, newest record at the tail.
REQ-039 SHALL pass: snoop write to BASE+0x2C with data 0 -> not logged; a subsequent write is not captured; CLR -> STATUS 0x40000000.
REQ-040 SHALL pass: reset asserted mid-stream with 3 records held -> all outputs 0 immediately; STATUS 0x40000000 after release.
